// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into one-shot press, release, click,
// double-click and long-press pulses.
module button_event_decoder #(
   parameter int unsigned LONG_CNT = 50,
   parameter int unsigned DBL_GAP  = 20,
   parameter int unsigned CNT_W    = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_data,
   output logic o_press,
   output logic o_release,
   output logic o_click,
   output logic o_dclick,
   output logic o_long,
   output logic o_busy
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS1,
      S_WAIT2,
      S_PRESS2,
      S_LONG
   } state_t;

   state_t           state;
   logic             d_q;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] gcnt;
   logic             rise_c;
   logic             fall_c;

   assign rise_c = i_data & ~d_q;
   assign fall_c = ~i_data & d_q;

   // o_busy is updated on every state change so it always mirrors state != IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         d_q       <= 1'b0;
         hcnt      <= '0;
         gcnt      <= '0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_click   <= 1'b0;
         o_dclick  <= 1'b0;
         o_long    <= 1'b0;
         o_busy    <= 1'b0;
      end else begin
         d_q       <= i_data;
         o_press   <= rise_c;
         o_release <= fall_c;
         o_click   <= 1'b0;
         o_dclick  <= 1'b0;
         o_long    <= 1'b0;

         case (state)
            S_IDLE: begin
               if (rise_c) begin
                  state  <= S_PRESS1;
                  hcnt   <= '0;
                  o_busy <= 1'b1;
               end
            end

            S_PRESS1, S_PRESS2: begin
               if (i_data) begin
                  if (hcnt == HOLD_LAST) begin
                     o_long <= 1'b1;
                     state  <= S_LONG;
                  end else begin
                     hcnt <= hcnt + CNT_ONE;
                  end
               end else if (state == S_PRESS2) begin
                  o_dclick <= 1'b1;
                  state    <= S_IDLE;
                  o_busy   <= 1'b0;
               end else begin
                  state <= S_WAIT2;
                  gcnt  <= '0;
               end
            end

            S_WAIT2: begin
               // A press on the final gap sample loses to the click and restarts
               if (!i_data) begin
                  if (gcnt == GAP_LAST) begin
                     o_click <= 1'b1;
                     state   <= S_IDLE;
                     o_busy  <= 1'b0;
                  end else begin
                     gcnt <= gcnt + CNT_ONE;
                  end
               end else if (gcnt == GAP_LAST) begin
                  o_click <= 1'b1;
                  state   <= S_PRESS1;
                  hcnt    <= '0;
               end else begin
                  state <= S_PRESS2;
                  hcnt  <= '0;
               end
            end

            S_LONG: begin
               if (fall_c) begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end
            end

            default: begin
               state  <= S_IDLE;
               o_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed test-plan sequences plus random
// press/release runs, checked against a timestamp-based reference model.
module tb_button_event_decoder;

   localparam int unsigned LONG_CNT = 8;
   localparam int unsigned DBL_GAP  = 5;
   localparam int unsigned CNT_W    = 16;

   logic clk = 1'b0;
   logic rst;
   logic i_data;
   logic o_press, o_release, o_click, o_dclick, o_long, o_busy;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: sequence phase plus edge timestamps
   int m_t    = 0;
   bit m_prev = 1'b0;
   int m_seq  = 0;   // 0 none, 1 first press, 2 second press, 3 long held
   bit m_rel  = 1'b0;
   int m_tp   = 0;
   int m_tr   = 0;
   bit e_press, e_release, e_click, e_dclick, e_long, e_busy;

   int c_press, c_release, c_click, c_dclick, c_long;

   button_event_decoder #(
      .LONG_CNT(LONG_CNT),
      .DBL_GAP (DBL_GAP),
      .CNT_W   (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .i_data   (i_data),
      .o_press  (o_press),
      .o_release(o_release),
      .o_click  (o_click),
      .o_dclick (o_dclick),
      .o_long   (o_long),
      .o_busy   (o_busy)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input bit r, input bit lvl);
      bit rise, fall;
      m_t++;
      e_press = 0; e_release = 0; e_click = 0; e_dclick = 0; e_long = 0;
      if (r) begin
         m_prev = 0; m_seq = 0; m_rel = 0;
      end else begin
         rise = lvl && !m_prev;
         fall = !lvl && m_prev;
         e_press   = rise;
         e_release = fall;
         if ((m_seq == 1 || m_seq == 2) && !m_rel) begin
            if (lvl && (m_t - m_tp) == int'(LONG_CNT)) begin
               e_long = 1; m_seq = 3;
            end else if (fall) begin
               if (m_seq == 2) begin
                  e_dclick = 1; m_seq = 0;
               end else begin
                  m_rel = 1; m_tr = m_t;
               end
            end
         end else if (m_seq == 1 && m_rel) begin
            if ((m_t - m_tr) == int'(DBL_GAP)) begin
               e_click = 1;
               if (rise) begin m_seq = 1; m_tp = m_t; m_rel = 0; end
               else m_seq = 0;
            end else if (rise) begin
               m_seq = 2; m_tp = m_t; m_rel = 0;
            end
         end else if (m_seq == 3) begin
            if (fall) m_seq = 0;
         end else if (rise) begin
            m_seq = 1; m_tp = m_t; m_rel = 0;
         end
         m_prev = lvl;
      end
      e_busy = (m_seq != 0);
   endtask

   task automatic cyc(input bit r, input bit lvl);
      @(negedge clk);
      rst    = r;
      i_data = lvl;
      model_step(r, lvl);
      @(posedge clk);
      #1;
      chk("press",   int'(o_press),   int'(e_press));
      chk("release", int'(o_release), int'(e_release));
      chk("click",   int'(o_click),   int'(e_click));
      chk("dclick",  int'(o_dclick),  int'(e_dclick));
      chk("long",    int'(o_long),    int'(e_long));
      chk("busy",    int'(o_busy),    int'(e_busy));
      c_press   += int'(o_press);
      c_release += int'(o_release);
      c_click   += int'(o_click);
      c_dclick  += int'(o_dclick);
      c_long    += int'(o_long);
   endtask

   task automatic run(input bit lvl, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, lvl);
   endtask

   task automatic clr_cnt();
      c_press = 0; c_release = 0; c_click = 0; c_dclick = 0; c_long = 0;
   endtask

   task automatic chk_cnt(input string tag, input int p, input int r, input int c,
                          input int d, input int l);
      chk({tag, "_npress"},   c_press,   p);
      chk({tag, "_nrelease"}, c_release, r);
      chk({tag, "_nclick"},   c_click,   c);
      chk({tag, "_ndclick"},  c_dclick,  d);
      chk({tag, "_nlong"},    c_long,    l);
   endtask

   initial begin
      bit lvl;
      rst    = 1'b1;
      i_data = 1'b0;
      clr_cnt();

      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0);
      run(1'b0, 10);
      chk_cnt("reset", 0, 0, 0, 0, 0);

      clr_cnt(); run(1'b1, 3); run(1'b0, 8);
      chk_cnt("single", 1, 1, 1, 0, 0);

      clr_cnt(); run(1'b1, 3); run(1'b0, 2); run(1'b1, 3); run(1'b0, 8);
      chk_cnt("double", 2, 2, 0, 1, 0);

      clr_cnt(); run(1'b1, 12); run(1'b0, 8);
      chk_cnt("long", 1, 1, 0, 0, 1);

      clr_cnt(); run(1'b1, 8); run(1'b0, 8);
      chk_cnt("hold8", 1, 1, 1, 0, 0);

      clr_cnt(); run(1'b1, 3); run(1'b0, 5); run(1'b1, 3); run(1'b0, 8);
      chk_cnt("gapedge", 2, 2, 2, 0, 0);

      clr_cnt(); run(1'b1, 5); cyc(1'b1, 1'b1); run(1'b1, 10); run(1'b0, 8);
      chk_cnt("midrst", 2, 1, 0, 0, 1);

      lvl = 1'b0;
      for (int i = 0; i < 300; i++) begin
         lvl = ~lvl;
         if ($urandom_range(0, 19) == 0) cyc(1'b1, lvl);
         run(lvl, int'($urandom_range(1, lvl ? 12 : 8)));
      end
      run(1'b0, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
